// File: rtl/rx_width_upsizer.sv
// Narrow-to-wide lane packer for the PHY receive path: packs RATIO beats of IN_W
// bits into one word, with valid/ready on both sides, lane-order select and partial flush.
module rx_width_upsizer #(
    parameter int IN_W      = 8,
    parameter int RATIO     = 4,
    parameter bit MSB_FIRST = 1'b1,
    parameter int CNT_W     = 16
) (
    input  logic                  notclk_4f,
    input  logic                  reset,
    input  logic [IN_W-1:0]       data_in,
    input  logic                  valid_in,
    output logic                  ready_out,
    input  logic                  flush,
    output logic [IN_W*RATIO-1:0] data_out,
    output logic [RATIO-1:0]      keep_out,
    output logic                  valid_out,
    input  logic                  ready_in,
    output logic [CNT_W-1:0]      word_count
);

    localparam int OUT_W = IN_W * RATIO;
    localparam int CW    = $clog2(RATIO);
    localparam logic [CW-1:0] LAST = CW'(RATIO - 1);

    logic [CW-1:0]    cnt;
    logic [OUT_W-1:0] acc;
    logic [RATIO-1:0] acc_keep;
    logic             flush_pend;

    logic [CW-1:0]    lane;
    logic [OUT_W-1:0] beat_word;
    logic [RATIO-1:0] beat_keep;
    logic             last_beat;
    logic             accept;
    logic             handoff;
    logic             slot_free;

    assign last_beat = (cnt == LAST);
    // Only the completing beat needs a free output slot; earlier beats go to the accumulator.
    assign ready_out = !flush_pend && !(last_beat && valid_out && !ready_in);
    assign accept    = valid_in && ready_out;
    assign handoff   = valid_out && ready_in;
    assign slot_free = !valid_out || ready_in;

    always_comb begin
        lane      = MSB_FIRST ? (LAST - cnt) : cnt;
        beat_word = '0;
        beat_keep = '0;
        for (int i = 0; i < RATIO; i++) begin
            if (lane == CW'(i)) begin
                beat_word[i*IN_W +: IN_W] = data_in;
                beat_keep[i]              = 1'b1;
            end
        end
    end

    always_ff @(posedge notclk_4f) begin
        if (reset) begin
            cnt        <= '0;
            acc        <= '0;
            acc_keep   <= '0;
            flush_pend <= 1'b0;
            data_out   <= '0;
            keep_out   <= '0;
            valid_out  <= 1'b0;
            word_count <= '0;
        end else begin
            if (handoff) begin
                valid_out  <= 1'b0;
                word_count <= word_count + CNT_W'(1);
            end

            if (accept) begin
                if (last_beat) begin
                    data_out  <= acc | beat_word;
                    keep_out  <= '1;
                    valid_out <= 1'b1;
                    cnt       <= '0;
                    acc       <= '0;
                    acc_keep  <= '0;
                end else begin
                    acc      <= acc | beat_word;
                    acc_keep <= acc_keep | beat_keep;
                    cnt      <= cnt + CW'(1);
                    if (flush) begin
                        flush_pend <= 1'b1;
                    end
                end
            end else if (flush && cnt != '0) begin
                flush_pend <= 1'b1;
            end

            // No beat can be accepted while flush_pend is set, so this never races the load above.
            if (flush_pend && slot_free) begin
                data_out   <= acc;
                keep_out   <= acc_keep;
                valid_out  <= 1'b1;
                cnt        <= '0;
                acc        <= '0;
                acc_keep   <= '0;
                flush_pend <= 1'b0;
            end
        end
    end

endmodule

// File: doc/rx_width_upsizer.md
Name: rx_width_upsizer

Overview:
Parametrised narrow-to-wide lane packer for the PHY receive path. It is the successor of the fixed 8-to-32 byte packer. It accumulates RATIO beats of IN_W bits into one OUT_W word and hands each word downstream over a valid/ready handshake. Compared with the fixed packer it adds:
- Backpressure in both directions.
- Configurable lane order.
- Partial-word flush with a lane keep mask.
- A word counter.

Parameters:
IN_W, 8, input beat width in bits
RATIO, 4, beats per output word (>=2); OUT_W = IN_W*RATIO is a derived localparam
MSB_FIRST, 1, 1: first beat of a word lands in the top lane; 0: first beat lands in lane 0
CNT_W, 16, width of word_count

Ports:
notclk_4f  in  1  block clock; all state updates on its posedge
reset  in  1  synchronous, active-high
data_in  in  IN_W  input beat
valid_in  in  1  beat present
ready_out  out  1  block can accept a beat this cycle
flush  in  1  request to emit the current partial word
data_out  out  OUT_W  packed word
keep_out  out  RATIO  per-lane valid mask for data_out
valid_out  out  1  data_out/keep_out valid
ready_in  in  1  downstream accepts word
word_count  out  CNT_W  count of words handed off

Behaviour:
- Reset is active-high and synchronous to notclk_4f; the clock is notclk_4f. On reset all of the following clear to 0: data_out, keep_out, valid_out, word_count, lane counter cnt, accumulator, flush_pend.
  - Any partial word is discarded.
  - ready_out reads 1 the cycle after reset releases.
- Beat accept: valid_in && ready_out at a posedge. A beat is never lost or duplicated. valid_in may drop between beats; the partial word is held indefinitely (no timeout, no clearing).
- Lane placement for beat index k (0..RATIO-1) within a word:
  - MSB_FIRST=1: bits [OUT_W-1-k*IN_W -: IN_W], keep bit RATIO-1-k.
  - MSB_FIRST=0: bits [k*IN_W +: IN_W], keep bit k.
- cnt counts accepted beats of the current word, 0..RATIO-1.
- Output slot is free when valid_out==0 or (valid_out && ready_in).
- Completing beat (accepted with cnt==RATIO-1):
  - The accumulator plus this beat loads data_out; keep_out loads all ones; valid_out is set at the same edge (1-cycle latency from accept to valid_out).
  - cnt returns to 0 and the accumulator clears.
- ready_out = !flush_pend && !(cnt==RATIO-1 && valid_out && !ready_in). This is combinational from state and ready_in. Beats 0..RATIO-2 are accepted even while the output slot is full.
- Handoff occurs on valid_out && ready_in.
  - word_count increments on each handoff and wraps modulo 2^CNT_W.
  - valid_out clears unless a new word loads at the same edge; back-to-back words therefore give full throughput with ready_in held high.
- data_out and keep_out hold stable while valid_out && !ready_in.
- Flush:
  - flush is sampled each cycle. If flush=1 and (cnt>0 or a beat is accepted this cycle), flush_pend is set.
  - A beat accepted in the same cycle as flush belongs to the flushed word.
  - flush with cnt==0 and no beat accepted is a no-op.
  - While flush_pend=1, ready_out=0. At the first edge where the output slot is free:
    - the partial word loads data_out;
    - keep_out gets only the filled lanes;
    - unfilled lanes are 0;
    - valid_out=1, cnt=0, flush_pend=0.
  - If the flush beat itself completes the word, it emits as a normal full word and flush_pend is not set.
- Reset mid-operation, including during flush_pend or with valid_out high, wins over all other events in that cycle.

Test Plan:
- IN_W=8, RATIO=4, MSB_FIRST=1, ready_in=1; beats 0x11,0x22,0x33,0x44 on consecutive cycles -> one cycle after the 4th accept: data_out=0x11223344, keep_out=4'b1111, valid_out=1 for 1 cycle, word_count=1.
- Same stream with MSB_FIRST=0 -> data_out=0x44332211, keep_out=4'b1111.
- 8 continuous beats 0x01..0x08 with ready_in held 0 until cycle 10:
  - word 0x01020304 is presented and held stable;
  - 0x05,0x06,0x07 are accepted;
  - ready_out=0 with cnt==3;
  - after ready_in rises, 0x08 is accepted and the second word is 0x05060708;
  - no loss, word_count=2.
- Beats 0xAA,0xBB, then flush=1 with no beat -> data_out=0xAABB0000, keep_out=4'b1100, cnt back to 0. Next beats 0xCC..0xFF give 0xCCDDEEFF.
- Beat 0x5A accepted together with flush while valid_out=1, ready_in=0:
  - ready_out stays 0 until the slot drains;
  - then data_out=0x5A000000, keep_out=4'b1000.
- Reset asserted after 2 beats with valid_out high -> next cycle all outputs 0, word_count=0. Fresh beats 0x10,0x20,0x30,0x40 give 0x10203040.
